layer_output_serializer: RTL

//  Sits directly downstream of one layer's neuron array. Captures the results of all

---
 rtl/layer_output_serializer_pkg.sv | 9 +
 rtl/layer_output_serializer.sv | 94 +++++++++
 2 files changed

// File: rtl/layer_output_serializer_pkg.sv
// Shared types for the layer output serializer: the two-state burst FSM encoding.
package layer_output_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/layer_output_serializer.sv
// Captures one full layer of neuron results and replays them one word per handshake,
// in neuron order, flagging partial completions and captures that land mid-drain.
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons-1:0]           neuronOutValid,
  input  logic [numNeurons*dataWidth-1:0] neuronOut,
  input  logic                            outReady,
  output logic [dataWidth-1:0]            outData,
  output logic                            outValid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            mismatch
);

  localparam int idxWidth = $clog2(numNeurons);
  localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numNeurons - 1);

  state_e                                state, state_nxt;
  logic [numNeurons-1:0][dataWidth-1:0]  hold;
  logic [idxWidth-1:0]                   idx, idx_inc;
  logic                                  cap, part, xfer, last_xfer;
  logic                                  load, advance, ovr_set;

  assign cap       = &neuronOutValid;
  assign part      = (|neuronOutValid) & ~cap;
  assign xfer      = outValid & outReady;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign idx_inc   = idx + 1'b1;
  assign busy      = (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A capture coinciding with the final handshake chains straight into the next
  // burst; any other capture while draining is dropped and reported as overrun.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load      = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          if (cap) load = 1'b1;
          else     state_nxt = IDLE;
        end else begin
          advance = xfer;
          ovr_set = cap;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold     <= '0;
      idx      <= '0;
      outData  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (load) begin
        hold     <= neuronOut;
        outData  <= neuronOut[dataWidth-1:0];
        outValid <= 1'b1;
        idx      <= '0;
      end else if (advance) begin
        idx      <= idx_inc;
        outData  <= hold[idx_inc];
      end else if (last_xfer) begin
        outValid <= 1'b0;
      end
      if (ovr_set) overrun  <= 1'b1;
      if (part)    mismatch <= 1'b1;
    end
  end

endmodule
